// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg -- shared types and complex-arithmetic helpers for FFT stages.
//
// Contents:
//   state_t     : stage FSM states (FILL, BFLY, DRAIN)
//   wide_t      : signed working word, wide enough for any stage intermediate
//   cplx_t      : packed complex {im, re} of wide_t
//   outWidth    : output component width; depends on macro R2SDF_SCALE_EN
//   sext/cSext  : sign-extend a value held in the low w bits to the full word
//   cAdd/cSub   : complex add / subtract on full words
//   cRound      : per component (x + 1) >>> 1 (halve, round half up)
//   cFits       : true when both components are representable in w bits
// Stage data widths must stay at least 2 bits below MaxW.
// -----------------------------------------------------------------------------
package fft_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    BFLY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int MaxW = 32;

  typedef logic signed [MaxW-1:0] wide_t;

  typedef struct packed {
    wide_t im;
    wide_t re;
  } cplx_t;

  // With scaling the extra butterfly bit is rounded away again.
  function automatic int outWidth(input int dataWidth);
`ifdef R2SDF_SCALE_EN
    return dataWidth;
`else
    return dataWidth + 1;
`endif
  endfunction

  function automatic wide_t sext(input wide_t x, input int w);
    return (x <<< (MaxW - w)) >>> (MaxW - w);
  endfunction

  function automatic cplx_t cSext(input cplx_t c, input int w);
    cplx_t r;
    r.re = sext(c.re, w);
    r.im = sext(c.im, w);
    return r;
  endfunction

  function automatic cplx_t cAdd(input cplx_t a, input cplx_t b);
    cplx_t r;
    r.re = a.re + b.re;
    r.im = a.im + b.im;
    return r;
  endfunction

  function automatic cplx_t cSub(input cplx_t a, input cplx_t b);
    cplx_t r;
    r.re = a.re - b.re;
    r.im = a.im - b.im;
    return r;
  endfunction

  function automatic cplx_t cRound(input cplx_t c);
    cplx_t r;
    r.re = (c.re + wide_t'(1)) >>> 1;
    r.im = (c.im + wide_t'(1)) >>> 1;
    return r;
  endfunction

  function automatic logic cFits(input cplx_t c, input int w);
    return cSext(c, w) == c;
  endfunction

endpackage

// File: rtl/r2sdf_stage_if.sv
// -----------------------------------------------------------------------------
// r2sdf_stage_if -- streaming bus of one radix-2 SDF stage.
//
//   en         : global clock enable
//   valid_in   : input sample valid
//   data_in    : complex input {im, re}, DATA_WIDTH bits each
//   flush_in   : drain request (honoured only at a frame boundary)
//   valid_out  : output valid, one cycle per emitted value
//   data_out   : complex output {im, re}, OUT_WIDTH bits each
//   busy_out   : drain in progress
// Modports: master drives the stage, slave is the stage itself.
// OUT_WIDTH follows macro R2SDF_SCALE_EN through fft_pkg::outWidth.
// -----------------------------------------------------------------------------
interface r2sdf_stage_if import fft_pkg::*; #(
  parameter int DATA_WIDTH = 16
) ();

  localparam int OUT_WIDTH = outWidth(DATA_WIDTH);

  logic                    en;
  logic                    valid_in;
  logic [2*DATA_WIDTH-1:0] data_in;
  logic                    flush_in;
  logic                    valid_out;
  logic [2*OUT_WIDTH-1:0]  data_out;
  logic                    busy_out;

  modport master (
    output en, valid_in, data_in, flush_in,
    input  valid_out, data_out, busy_out
  );

  modport slave (
    input  en, valid_in, data_in, flush_in,
    output valid_out, data_out, busy_out
  );

endinterface

// File: rtl/r2sdf_delay_line.sv
// -----------------------------------------------------------------------------
// r2sdf_delay_line -- DELAY-deep circular buffer for the SDF feedback path.
//
//   clk, rst : clock, synchronous active-high reset (pointer only)
//   adv      : write wrData at the pointer and step the pointer
//   wrData   : word to store
//   rdData   : word at the pointer, i.e. the one written DELAY advances ago
// One pointer serves both read and write, so the head is always the oldest
// entry and no separate occupancy tracking is needed.
// -----------------------------------------------------------------------------
module r2sdf_delay_line #(
  parameter int WIDTH = 34,
  parameter int DELAY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData
);

  localparam int PtrW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DELAY - 1);

  logic [WIDTH-1:0] mem [DELAY];
  logic [PtrW-1:0]  ptr;

  assign rdData = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (ptr == PtrLast) ? '0 : ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; nothing is read before it has been written,
  // and leaving it unreset lets the buffer map onto plain RAM/SRL cells.
  always_ff @(posedge clk) begin
    if (adv) begin
      mem[ptr] <= wrData;
    end
  end

endmodule

// File: rtl/r2sdf_stage.sv
// -----------------------------------------------------------------------------
// r2sdf_stage -- one radix-2 single-path delay-feedback FFT stage.
//
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : r2sdf_stage_if.slave (en, valid_in, data_in, flush_in,
//          valid_out, data_out, busy_out)
// Parameters: DATA_WIDTH (input component width), DELAY (power of two, >= 1).
// A frame is 2*DELAY samples. The first half is parked in the delay line;
// during the second half each head a pairs with input b: a+b goes out, a-b
// goes back into the line and is emitted while the next frame fills, or on a
// flush-triggered DRAIN.
// Option macro R2SDF_SCALE_EN: outputs are halved with round-half-up and keep
// DATA_WIDTH bits; otherwise outputs are full precision (DATA_WIDTH+1 bits).
// -----------------------------------------------------------------------------
module r2sdf_stage import fft_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int DELAY      = 4
) (
  input  logic           clk,
  input  logic           rst,
  r2sdf_stage_if.slave   bus
);

  localparam int LineW = DATA_WIDTH + 1;
  localparam int OutW  = outWidth(DATA_WIDTH);
  localparam int CntW  = $clog2(2 * DELAY);
  localparam logic [CntW-1:0] LastFill = CntW'(DELAY - 1);
  localparam logic [CntW-1:0] LastBfly = CntW'(2 * DELAY - 1);

  state_t          state, stateNext;
  logic [CntW-1:0] cnt, cntNext;
  logic            pend, pendNext;

  cplx_t inExt, head, lineWr, emitVal, outVal;
  logic  lineAdv, emit;
  logic [2*LineW-1:0] lineRd, lineWrPacked;

  // Input and delay-line words widened to the working word.
  always_comb begin
    inExt.re = sext(wide_t'(bus.data_in[DATA_WIDTH-1:0]), DATA_WIDTH);
    inExt.im = sext(wide_t'(bus.data_in[2*DATA_WIDTH-1:DATA_WIDTH]), DATA_WIDTH);
    head.re  = sext(wide_t'(lineRd[LineW-1:0]), LineW);
    head.im  = sext(wide_t'(lineRd[2*LineW-1:LineW]), LineW);
  end

  assign lineWrPacked = {lineWr.im[LineW-1:0], lineWr.re[LineW-1:0]};

  r2sdf_delay_line #(
    .WIDTH (2 * LineW),
    .DELAY (DELAY)
  ) u_line (
    .clk    (clk),
    .rst    (rst),
    .adv    (lineAdv),
    .wrData (lineWrPacked),
    .rdData (lineRd)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      pend  <= pendNext;
    end
  end

  // In DRAIN, cnt doubles as the drain step counter; it is back at 0 on exit.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    pendNext  = pend;
    lineAdv   = 1'b0;
    lineWr    = inExt;
    emit      = 1'b0;
    emitVal   = '0;
    if (bus.en) begin
      unique case (state)
        FILL: begin
          // A flush only means something at a frame boundary with differences
          // pending; it also wins over a simultaneous sample.
          if (bus.flush_in && cnt == '0 && pend) begin
            stateNext = DRAIN;
          end else if (bus.valid_in) begin
            lineAdv = 1'b1;
            if (pend) begin
              emit    = 1'b1;
              emitVal = head;
            end
            cntNext = cnt + 1'b1;
            if (cnt == LastFill) begin
              stateNext = BFLY;
              pendNext  = 1'b0;
            end
          end
        end
        BFLY: begin
          if (bus.valid_in) begin
            lineAdv = 1'b1;
            lineWr  = cSub(head, inExt);
            emit    = 1'b1;
            emitVal = cAdd(head, inExt);
            cntNext = cnt + 1'b1;
            if (cnt == LastBfly) begin
              stateNext = FILL;
              pendNext  = 1'b1;
            end
          end
        end
        DRAIN: begin
          // Rewrite the head unchanged so the pointer keeps its frame alignment.
          lineAdv = 1'b1;
          lineWr  = head;
          emit    = 1'b1;
          emitVal = head;
          if (cnt == LastFill) begin
            stateNext = FILL;
            cntNext   = '0;
            pendNext  = 1'b0;
          end else begin
            cntNext = cnt + 1'b1;
          end
        end
        default: stateNext = FILL;
      endcase
    end
  end

`ifdef R2SDF_SCALE_EN
  assign outVal = cRound(emitVal);
`else
  assign outVal = emitVal;
`endif

  assign bus.busy_out = (state == DRAIN);

  // data_out only changes when a value is emitted; otherwise it holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
    end else if (bus.en) begin
      bus.valid_out <= emit;
      if (emit) begin
        bus.data_out <= {outVal.im[OutW-1:0], outVal.re[OutW-1:0]};
      end
    end
  end

  // Truncation to the line and output widths must never drop significant bits.
  always_ff @(posedge clk) begin
    if (!rst && bus.en) begin
      assert (cFits(lineWr, LineW) && cFits(outVal, OutW));
    end
  end

endmodule
